// File: rtl/fft_outputs_to_peak_finder_pkg.sv
// Shared sizes, FSM encoding and the tagged magnitude word used by the FFT read-out path.
package fft_outputs_to_peak_finder_pkg;

    localparam int unsigned N_FFT   = 4;
    localparam int unsigned BINS    = 512;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned MAG_W   = 24;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CORE_W  = $clog2(N_FFT);
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [MAG_W-1:0]   data;
        logic [ADDR_W-1:0]  bin;
        logic [FRAME_W-1:0] frame;
        logic               sof;
        logic               eof;
    } tag_word_t;

endpackage

// File: rtl/fft_outputs_to_peak_finder_if.sv
// Core-buffer read port plus the tagged output stream of the FFT read-out block.
interface fft_outputs_to_peak_finder_if
    import fft_outputs_to_peak_finder_pkg::*;
#(
    parameter int unsigned FW = FRAME_W
);
    logic [N_FFT-1:0]       fft_done;
    logic [N_FFT-1:0]       fft_rd_en;
    logic [ADDR_W-1:0]      fft_rd_addr;
    logic [N_FFT*MAG_W-1:0] fft_rd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [MAG_W-1:0]       out_data;
    logic [ADDR_W-1:0]      out_bin;
    logic [FW-1:0]          out_frame;
    logic                   out_sof;
    logic                   out_eof;
    logic                   overrun;
    logic                   busy;

    modport master (
        input  fft_done, fft_rd_data, out_ready,
        output fft_rd_en, fft_rd_addr, out_valid, out_data, out_bin,
               out_frame, out_sof, out_eof, overrun, busy
    );

    modport slave (
        output fft_done, fft_rd_data, out_ready,
        input  fft_rd_en, fft_rd_addr, out_valid, out_data, out_bin,
               out_frame, out_sof, out_eof, overrun, busy
    );
endinterface

// File: rtl/fft_outputs_to_peak_finder_skid_fifo2.sv
// Two-entry FIFO of tagged words; entry 0 is always the head presented downstream.
module fft_outputs_to_peak_finder_skid_fifo2
    import fft_outputs_to_peak_finder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  tag_word_t        push_word,
    input  logic             pop,
    output tag_word_t        head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    tag_word_t        ent0_q, ent0_d, ent1_q, ent1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (push && pop) begin
            if (cnt_q == CNT_W'(2)) begin
                ent0_d = ent1_q;
                ent1_d = push_word;
            end else begin
                ent0_d = push_word;
                cnt_d  = CNT_W'(1);
            end
        end else if (push) begin
            if (cnt_q == CNT_W'(0)) begin
                ent0_d = push_word;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q == CNT_W'(1)) begin
                ent1_d = push_word;
                cnt_d  = CNT_W'(2);
            end
        end else if (pop && cnt_q != CNT_W'(0)) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = ent0_q;
    assign valid = (cnt_q != CNT_W'(0));
    assign count = cnt_q;
endmodule

// File: rtl/fft_outputs_to_peak_finder.sv
// Drains four FFT magnitude buffers in strict round-robin frame order into one tagged stream.
module fft_outputs_to_peak_finder
    import fft_outputs_to_peak_finder_pkg::*;
#(
    parameter int unsigned FW = FRAME_W
)(
    input  logic clk,
    input  logic reset,
    fft_outputs_to_peak_finder_if.master bus
);
    state_e            state_q, state_d;
    logic [N_FFT-1:0]  pending_q, pending_d;
    logic [CORE_W-1:0] exp_q, exp_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_bin_q, inflight_bin_d;
    logic              overrun_q, overrun_d;

    logic [N_FFT-1:0]  exp_onehot_c, draining_c;
    logic [MAG_W-1:0]  rd_word_c;
    logic [CNT_W-1:0]  fifo_cnt_c;
    logic [2:0]        occ_c;
    logic              issue_c, pop_c, head_valid_c;
    tag_word_t         push_word_c, head_c;

    assign exp_onehot_c = N_FFT'(1) << exp_q;
    assign draining_c   = (state_q != ST_IDLE) ? exp_onehot_c : '0;
    assign pop_c        = head_valid_c & bus.out_ready;
    // Occupancy after this cycle's pop, counting the read whose data lands this cycle.
    assign occ_c        = 3'(fifo_cnt_c) + 3'(inflight_q) - 3'(pop_c);
    assign issue_c      = (state_q == ST_READ) && (occ_c < 3'd2);

    always_comb begin
        rd_word_c = '0;
        for (int k = 0; k < N_FFT; k++) begin
            if (exp_q == CORE_W'(k)) rd_word_c = bus.fft_rd_data[k*MAG_W +: MAG_W];
        end
    end

    assign push_word_c = '{data:  rd_word_c,
                           bin:   inflight_bin_q,
                           frame: FRAME_W'(frame_q),
                           sof:   (inflight_bin_q == ADDR_W'(0)),
                           eof:   (inflight_bin_q == ADDR_W'(BINS-1))};

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        exp_d          = exp_q;
        frame_d        = frame_q;
        rd_addr_d      = rd_addr_q;
        inflight_d     = issue_c;
        inflight_bin_d = issue_c ? rd_addr_q : inflight_bin_q;
        overrun_d      = overrun_q | (|(bus.fft_done & (pending_q | draining_c)));
        case (state_q)
            ST_IDLE: begin
                if (pending_q[exp_q]) begin
                    state_d          = ST_READ;
                    pending_d[exp_q] = 1'b0;
                    rd_addr_d        = '0;
                end
            end
            ST_READ: begin
                if (issue_c) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == ADDR_W'(BINS-1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_c && head_c.eof) begin
                    state_d = ST_IDLE;
                    exp_d   = (exp_q == CORE_W'(N_FFT-1)) ? '0 : exp_q + 1'b1;
                    frame_d = frame_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new completion always leaves its pending bit set, even while being cleared.
        pending_d = pending_d | bus.fft_done;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            exp_q          <= '0;
            frame_q        <= '0;
            rd_addr_q      <= '0;
            inflight_q     <= 1'b0;
            inflight_bin_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            exp_q          <= exp_d;
            frame_q        <= frame_d;
            rd_addr_q      <= rd_addr_d;
            inflight_q     <= inflight_d;
            inflight_bin_q <= inflight_bin_d;
            overrun_q      <= overrun_d;
        end
    end

    fft_outputs_to_peak_finder_skid_fifo2 u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_word (push_word_c),
        .pop       (pop_c),
        .head      (head_c),
        .valid     (head_valid_c),
        .count     (fifo_cnt_c)
    );

    assign bus.fft_rd_en   = issue_c ? exp_onehot_c : '0;
    assign bus.fft_rd_addr = rd_addr_q;
    assign bus.out_valid   = head_valid_c;
    assign bus.out_data    = head_c.data;
    assign bus.out_bin     = head_c.bin;
    assign bus.out_frame   = FW'(head_c.frame);
    assign bus.out_sof     = head_c.sof;
    assign bus.out_eof     = head_c.eof;
    assign bus.overrun     = overrun_q;
    assign bus.busy        = (state_q != ST_IDLE);
endmodule
